// File: rtl/gameport_pkg.sv
// Shared types and helpers for the game-port timer.
// Axis value conversion (offset binary, optional deadzone snap).
package gameport_pkg;

    localparam int NUM_JOY_DEF = 2;
    localparam int AXIS_W_DEF  = 8;
    localparam int AXES        = 2 * NUM_JOY_DEF;

    typedef logic [AXIS_W_DEF-1:0] axis_t;

    // Flip the sign bit of a w-bit two's complement value.
    function automatic logic [31:0] to_offset(input logic [31:0] v,
                                              input int w);
        return v ^ (32'd1 << (w - 1));
    endfunction

    function automatic logic [31:0] deadzone(input logic [31:0] v,
                                             input int w,
                                             input int dz);
        logic [31:0] mask;
        logic [31:0] vm;
        logic [31:0] mag;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        vm   = v & mask;
        mag  = vm[w-1] ? (((32'd1 << w) - vm) & mask) : vm;
        if (vm[w-1] && mag == 32'd0)
            mag = 32'd1 << (w - 1);
        return (mag <= $unsigned(dz)) ? 32'd0 : vm;
    endfunction

endpackage

// File: rtl/gameport_prescaler.sv
// Restartable tick generator; period (cpu_speed+1)*2**DIV_LOG2 cycles.
// Uses >= so a lowered speed takes effect at once, without overshoot.
module gameport_prescaler #(
    parameter int DIV_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cpu_speed,
    input  logic       restart,
    output logic       tick
);

    localparam int CW = DIV_LOG2 + 4;

    logic [CW-1:0] cnt;
    logic [CW-1:0] period_m1;

    assign period_m1 = {cpu_speed, {DIV_LOG2{1'b1}}};
    assign tick      = (cnt >= period_m1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (restart)
            cnt <= CW'(1);
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/gameport_timer.sv
// Port 0x201 style game-port emulator: one-shot axis timing, live buttons.
// Optional macro GAMEPORT_DEADZONE_EN snaps small axis values to centre.
module gameport_timer
    import gameport_pkg::*;
#(
    parameter int NUM_JOY  = NUM_JOY_DEF,
    parameter int AXIS_W   = AXIS_W_DEF,
    parameter int DIV_LOG2 = 4,
    parameter int DEADZONE = 4
) (
    input  logic                         clk_cpu,
    input  logic                         reset,
    input  logic [3:0]                   cpu_speed,
    input  logic                         joyswap,
    input  logic                         port_wr,
    input  logic [2*NUM_JOY-1:0]         joy_btn,
    input  logic [2*NUM_JOY*AXIS_W-1:0]  joy_analog,
    output logic [4*NUM_JOY-1:0]         port_out,
    output logic                         busy
);

    localparam int NAXES = 2 * NUM_JOY;

    if (NUM_JOY < 2 || NUM_JOY > 4 || DIV_LOG2 < 1 || DEADZONE < 0
        || AXIS_W < 2 || AXIS_W > 32) begin : g_bad_cfg
        $error("gameport_timer: unsupported parameter set");
    end

    logic [AXIS_W-1:0] tgt_q [NAXES];
    logic [AXIS_W-1:0] tgt_d [NAXES];
    logic [NAXES-1:0]  axis_q;
    logic [NAXES-1:0]  hit;
    logic [NAXES-1:0]  btn_q;
    logic [NAXES-1:0]  btn_d;
    logic [AXIS_W-1:0] counter_q;
    logic              busy_q;
    logic              tick;

    function automatic logic [AXIS_W-1:0] conv(input logic [AXIS_W-1:0] v);
        logic [31:0] w;
        w = 32'(v);
`ifdef GAMEPORT_DEADZONE_EN
        w = deadzone(w, AXIS_W, DEADZONE);
`endif
        w = to_offset(w, AXIS_W);
        return w[AXIS_W-1:0];
    endfunction

    gameport_prescaler #(
        .DIV_LOG2 (DIV_LOG2)
    ) u_prescaler (
        .clk       (clk_cpu),
        .rst       (reset),
        .cpu_speed (cpu_speed),
        .restart   (port_wr),
        .tick      (tick)
    );

    // Only the first two sticks take part in the swap.
    always_comb begin
        for (int j = 0; j < NUM_JOY; j++) begin
            automatic int src = (joyswap && j < 2) ? (j ^ 1) : j;
            tgt_d[2*j]   = conv(joy_analog[src*2*AXIS_W + AXIS_W +: AXIS_W]);
            tgt_d[2*j+1] = conv(joy_analog[src*2*AXIS_W +: AXIS_W]);
            btn_d[2*j +: 2] = ~joy_btn[2*src +: 2];
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < NAXES; i++)
            hit[i] = (tgt_q[i] == counter_q);
    end

    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            axis_q    <= '0;
            btn_q     <= '1;
            busy_q    <= 1'b0;
            counter_q <= '1;
            for (int i = 0; i < NAXES; i++)
                tgt_q[i] <= '0;
        end else begin
            btn_q <= btn_d;
            if (port_wr) begin
                axis_q    <= '1;
                counter_q <= '0;
                busy_q    <= 1'b1;
                for (int i = 0; i < NAXES; i++)
                    tgt_q[i] <= tgt_d[i];
            end else if (busy_q) begin
                if (counter_q == '1) begin
                    axis_q <= '0;
                    busy_q <= 1'b0;
                end else begin
                    axis_q <= axis_q & ~hit;
                    if (tick)
                        counter_q <= counter_q + 1'b1;
                end
            end
        end
    end

    assign port_out = {btn_q, axis_q};
    assign busy     = busy_q;

endmodule

// File: tb/tb_gameport_timer.sv
// Directed bench for gameport_timer (NUM_JOY=2, AXIS_W=8, DIV_LOG2=4).
// Times are in cycles after the port_wr cycle n (trigger lands at n+1).
module tb_gameport_timer;

    logic        clk_cpu = 1'b0;
    logic        reset;
    logic [3:0]  cpu_speed;
    logic        joyswap;
    logic        port_wr;
    logic [3:0]  joy_btn;
    logic [31:0] joy_analog;
    logic [7:0]  port_out;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc;

    gameport_timer dut (
        .clk_cpu    (clk_cpu),
        .reset      (reset),
        .cpu_speed  (cpu_speed),
        .joyswap    (joyswap),
        .port_wr    (port_wr),
        .joy_btn    (joy_btn),
        .joy_analog (joy_analog),
        .port_out   (port_out),
        .busy       (busy)
    );

    always #5 clk_cpu = ~clk_cpu;

    task automatic step(input int n);
        repeat (n) @(posedge clk_cpu);
        #1;
    endtask

    task automatic set_axes(input logic [7:0] x0, input logic [7:0] y0,
                            input logic [7:0] x1, input logic [7:0] y1);
        joy_analog = {x1, y1, x0, y0};
    endtask

    // Leaves the bench at cycle n+1.
    task automatic trigger();
        port_wr = 1'b1;
        step(1);
        port_wr = 1'b0;
    endtask

    // Cycle index at which the selected signal (0..3 axis, 8 busy) is low.
    task automatic measure(input int sel, input int start, input int limit,
                           output int at);
        at = start;
        while (((sel == 8) ? busy : port_out[sel]) === 1'b1 && at < limit) begin
            step(1);
            at++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (port_out !== 8'hF0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_held port_out=%h busy=%b want f0/0", port_out, busy);
        end
        reset = 1'b0;
        step(3);
        checks++;
        if (port_out !== 8'hF0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle port_out=%h busy=%b want f0/0", port_out, busy);
        end
    endtask

    task automatic test_full_scale();
        cpu_speed = 4'd0;
        set_axes(8'h00, 8'h00, 8'h00, 8'h00);
        trigger();
        checks++;
        if (port_out[3:0] !== 4'hF || busy !== 1'b1) begin
            errors++;
            $display("FAIL trig_state axes=%h busy=%b want f/1", port_out[3:0], busy);
        end
        set_axes(8'h80, 8'h80, 8'h80, 8'h80);
        measure(0, 1, 5000, cyc);
        checks++;
        if (cyc !== 2049) begin
            errors++;
            $display("FAIL x0_centre cleared at %0d want 2049", cyc);
        end
        measure(8, cyc, 5000, cyc);
        checks++;
        if (cyc !== 4081) begin
            errors++;
            $display("FAIL busy_done dropped at %0d want 4081", cyc);
        end
        step(20);
        checks++;
        if (port_out[3:0] !== 4'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_done axes=%h busy=%b want 0/0", port_out[3:0], busy);
        end
    endtask

    task automatic test_extremes();
        set_axes(8'h00, 8'h00, 8'h00, 8'h80);
        trigger();
        checks++;
        if (port_out[3] !== 1'b1) begin
            errors++;
            $display("FAIL y1_min_n1 bit3=%b want 1", port_out[3]);
        end
        step(1);
        checks++;
        if (port_out[3] !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL y1_min_n2 bit3=%b busy=%b want 0/1", port_out[3], busy);
        end
        set_axes(8'h00, 8'h00, 8'h00, 8'h7F);
        trigger();
        measure(3, 1, 5000, cyc);
        checks++;
        if (cyc !== 4081 || busy !== 1'b0) begin
            errors++;
            $display("FAIL y1_max cleared at %0d busy=%b want 4081/0", cyc, busy);
        end
    endtask

    task automatic test_speed();
        cpu_speed = 4'd1;
        set_axes(8'hC0, 8'h00, 8'h00, 8'h00);
        trigger();
        measure(0, 1, 5000, cyc);
        checks++;
        if (cyc !== 2049) begin
            errors++;
            $display("FAIL speed1 cleared at %0d want 2049", cyc);
        end
        trigger();
        step(1019);
        checks++;
        if (port_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL speed_mid bit0=%b want 1", port_out[0]);
        end
        cpu_speed = 4'd0;
        measure(0, 1020, 5000, cyc);
        checks++;
        if (cyc !== 1534) begin
            errors++;
            $display("FAIL speed_drop cleared at %0d want 1534", cyc);
        end
    endtask

    task automatic test_swap_retrigger();
        joyswap = 1'b1;
        joy_btn = 4'b0001;
        step(1);
        checks++;
        if (port_out[7:4] !== 4'b1011) begin
            errors++;
            $display("FAIL swap_btn got %b want 1011", port_out[7:4]);
        end
        set_axes(8'h80, 8'h00, 8'h90, 8'h00);
        trigger();
        checks++;
        if (port_out[7:4] !== 4'b1011) begin
            errors++;
            $display("FAIL btn_on_wr got %b want 1011", port_out[7:4]);
        end
        measure(2, 1, 5000, cyc);
        checks++;
        if (cyc !== 2) begin
            errors++;
            $display("FAIL swap_x1 cleared at %0d want 2", cyc);
        end
        trigger();
        measure(0, 1, 5000, cyc);
        checks++;
        if (cyc !== 257) begin
            errors++;
            $display("FAIL swap_x0 cleared at %0d want 257", cyc);
        end
        joyswap = 1'b0;
        joy_btn = 4'b0000;
        set_axes(8'h00, 8'h00, 8'h00, 8'h00);
        trigger();
        step(159);
        checks++;
        if (port_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL retrig_pre bit0=%b want 1", port_out[0]);
        end
        set_axes(8'h8A, 8'h00, 8'h00, 8'h00);
        trigger();
        checks++;
        if (busy !== 1'b1 || port_out[3:0] !== 4'hF) begin
            errors++;
            $display("FAIL retrig_state busy=%b axes=%h want 1/f", busy, port_out[3:0]);
        end
        measure(0, 1, 5000, cyc);
        checks++;
        if (cyc !== 161) begin
            errors++;
            $display("FAIL retrig_x0 cleared at %0d want 161", cyc);
        end
    endtask

    task automatic test_deadzone();
        int want_small;
        int want_neg;
`ifdef GAMEPORT_DEADZONE_EN
        want_small = 2049;
        want_neg   = 2049;
`else
        want_small = 2097;
        want_neg   = 2001;
`endif
        set_axes(8'h03, 8'h00, 8'h00, 8'h00);
        trigger();
        measure(0, 1, 5000, cyc);
        checks++;
        if (cyc !== want_small) begin
            errors++;
            $display("FAIL dz_p3 cleared at %0d want %0d", cyc, want_small);
        end
        set_axes(8'h05, 8'h00, 8'h00, 8'h00);
        trigger();
        measure(0, 1, 5000, cyc);
        checks++;
        if (cyc !== 2129) begin
            errors++;
            $display("FAIL dz_p5 cleared at %0d want 2129", cyc);
        end
        set_axes(8'hFD, 8'h00, 8'h00, 8'h00);
        trigger();
        measure(0, 1, 5000, cyc);
        checks++;
        if (cyc !== want_neg) begin
            errors++;
            $display("FAIL dz_m3 cleared at %0d want %0d", cyc, want_neg);
        end
    endtask

    task automatic test_reset_mid();
        joy_btn = 4'b0000;
        set_axes(8'h00, 8'h00, 8'h00, 8'h00);
        trigger();
        step(100);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (port_out !== 8'hF0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid port_out=%h busy=%b want f0/0", port_out, busy);
        end
        step(1);
        reset = 1'b0;
        step(50);
        checks++;
        if (port_out !== 8'hF0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_quiet port_out=%h busy=%b want f0/0", port_out, busy);
        end
    endtask

    initial begin
        reset      = 1'b1;
        cpu_speed  = 4'd0;
        joyswap    = 1'b0;
        port_wr    = 1'b0;
        joy_btn    = 4'b0000;
        joy_analog = 32'h0;
        step(2);
        test_reset();
        test_full_scale();
        test_extremes();
        test_speed();
        test_swap_retrigger();
        test_deadzone();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gameport_timer.md
Name: gameport_timer

Overview:
Parametrised PC game-port (port 0x201 style) emulator for NUM_JOY analog joysticks. On a CPU port write it starts a one-shot measurement. Each axis bit stays high for a time proportional to that axis value; button bits are passed through active-low. It sits between user_io joystick outputs and the system GPIO_IN/GPIO_WR pins. It replaces the fixed 2-stick, 8-bit inline logic with latched targets, a busy flag, swap and speed-tracked timing.

Parameters:
NUM_JOY, 2, number of joysticks (2..4); each has X and Y axes and 2 buttons
AXIS_W, 8, width of one signed analog axis value and of the timing counter
DIV_LOG2, 4, base ticks-per-count at full speed = 2**DIV_LOG2 clk_cpu cycles
DEADZONE, 4, magnitude snapped to centre when GAMEPORT_DEADZONE_EN is defined

Ports:
clk_cpu  in  1  sole clock
reset  in  1  asynchronous, active-high reset
cpu_speed  in  4  CPU divider code; count period = (cpu_speed+1)*2**DIV_LOG2 cycles
joyswap  in  1  exchange joystick 0 and 1 (sampled at trigger)
port_wr  in  1  one-cycle trigger pulse from GPIO_WR
joy_btn  in  2*NUM_JOY  active-high buttons, bit 2j+b = joystick j button b
joy_analog  in  2*NUM_JOY*AXIS_W  per joystick j: [2*AXIS_W-1:AXIS_W]=X, [AXIS_W-1:0]=Y, two's complement
port_out  out  4*NUM_JOY  [2*NUM_JOY-1:0] axis bits (bit 2j+k, k=0 X, k=1 Y); [4*NUM_JOY-1:2*NUM_JOY] buttons active-low
busy  out  1  measurement in progress

Behaviour:
- Reset (async): axis bits 0, button bits all 1, busy 0, counter = all-ones (idle), prescaler 0, targets 0.
- Target conversion: target = {~v[AXIS_W-1], v[AXIS_W-2:0]} (offset binary, 0..2**AXIS_W-1). Targets latched on the port_wr cycle, after the swap is applied. Live inputs are ignored until the next trigger.
- Trigger: port_wr high in cycle n -> at n+1: axis bits all 1, counter 0, prescaler 1, busy 1, targets latched.
- Prescaler: increments each cycle. When it is >= (cpu_speed+1)*2**DIV_LOG2-1 it wraps to 0 and issues a tick. The >= comparison means a mid-measurement speed decrease takes effect at the next wrap with no overshoot.
- Counter: +1 per tick while busy. Every cycle while busy, an axis bit whose target equals the counter is cleared on the next edge. A target of 0 therefore clears at n+2.
- Completion: when the counter reaches all-ones, all axis bits are forced 0 and busy drops on the next edge. The counter saturates there.
- Retrigger while busy: full restart as in Trigger, with new targets latched.
- port_wr and completion in the same cycle: the trigger wins.
- Buttons: port_out button bit = ~joy_btn after 1 register stage, with joyswap applied live. Unaffected by port_wr.
- Idle: axis bits 0, busy 0.
- Joysticks numbered >= 2 are never swapped.

Optional Feature:
GAMEPORT_DEADZONE_EN:
- Defined: at latch time, any axis with |v| <= DEADZONE is replaced by 0, giving target 2**(AXIS_W-1).
- Undefined: values are latched unmodified and the DEADZONE parameter is unused.

Decomposition:
- Package gameport_pkg:
  - localparam AXES = 2*NUM_JOY
  - function to_offset(v) for the sign-flip conversion
  - function deadzone(v, dz)
  - typedef axis_t for logic [AXIS_W-1:0]
- Sub-module gameport_prescaler (cpu_speed, restart -> tick), reusable for other ISA-timed peripherals.

Test Plan:
1. Reset asserted mid-measurement -> port_out immediately = 8'hF0 with buttons released and axes 0 (NUM_JOY=2), busy 0; no activity until the next port_wr.
2. cpu_speed=0, X0=8'h00, port_wr at cycle 0 -> port_out[0] high from cycle 1 and low at cycle 1+128*16 (+/-1), busy low after 255 ticks = 4080 cycles.
3. Y1=8'h80 (target 0) -> port_out[3] high for exactly one cycle after the trigger. Y1=8'h7F -> bit stays high until completion, then drops with busy.
4. cpu_speed=1, X0=8'hC0 (target 64) -> bit clears at about 64*32 = 2048 cycles. Switch cpu_speed to 0 halfway -> the remaining ticks run at 16-cycle period, with no tick longer than 32 cycles.
5. joyswap=1, joy_btn=4'b0001 -> port_out[7:4]=4'b1011. Retrigger at tick 10 with new X0 -> timing restarts from 0 with the new target.
6. GAMEPORT_DEADZONE_EN, X0=8'h03 -> clears at tick 128. X0=8'h05 -> clears at tick 133. Without the macro, X0=8'h03 clears at tick 131.
